hazard_stall_ctrl: RTL and testbench

HAZARD_STALL_CTRL -- requirements
Module: hazard_stall_ctrl

---
 rtl/hazard_stall_ctrl.sv | 179 +++++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_stall_ctrl
//
// Load-use hazard stall controller for a classic 5-stage pipeline.
//
// Detects a load in EX whose destination feeds a source of the instruction in
// ID and holds the front end for N = LOAD_LAT (+ BR_EXTRA for BEQ/BNE) cycles.
// The first stall cycle is the detection cycle itself (zero latency). An
// accepted interrupt aborts any stall and raises a one-cycle flush.
//
// Parameters:
//   REG_W    register-index width
//   OPC_W    opcode width
//   LOAD_LAT load-use stall cycles (1..15)
//   BR_EXTRA extra stall cycles when the dependent instruction is BEQ/BNE (0..7)
//
// Ports:
//   clk          clock, rising edge
//   reset        asynchronous active-high reset
//   opcode_id    opcode of the decode instruction
//   rs_id        first source register of the decode instruction
//   rt_id        second source / target register of the decode instruction
//   opcode_ex    opcode of the execute instruction
//   rt_ex        destination register of the execute instruction
//   irq          interrupt accepted this cycle
//   stall        hold PC and IF/ID, bubble into ID/EX
//   flush        one-cycle flush on interrupt
//   stall_left   remaining stall cycles after the current one
//   stall_cycles (only with HAZARD_STALL_STATS_EN) saturating count of
//                cycles with stall high
//
// Optional feature macro: HAZARD_STALL_STATS_EN
// -----------------------------------------------------------------------------
module hazard_stall_ctrl #(
    parameter int REG_W    = 2,
    parameter int OPC_W    = 6,
    parameter int LOAD_LAT = 1,
    parameter int BR_EXTRA = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [OPC_W-1:0] opcode_id,
    input  logic [REG_W-1:0] rs_id,
    input  logic [REG_W-1:0] rt_id,
    input  logic [OPC_W-1:0] opcode_ex,
    input  logic [REG_W-1:0] rt_ex,
    input  logic             irq,
    output logic             stall,
    output logic             flush,
    output logic [3:0]       stall_left
`ifdef HAZARD_STALL_STATS_EN
    ,
    output logic [15:0]      stall_cycles
`endif
);

    // Shared opcode map (MIPS-style encodings)
    localparam logic [OPC_W-1:0] OPCODE_RTYPE = OPC_W'(6'h00);
    localparam logic [OPC_W-1:0] OPCODE_BEQ   = OPC_W'(6'h04);
    localparam logic [OPC_W-1:0] OPCODE_BNE   = OPC_W'(6'h05);
    localparam logic [OPC_W-1:0] OPCODE_LW    = OPC_W'(6'h23);
    localparam logic [OPC_W-1:0] OPCODE_SW    = OPC_W'(6'h2B);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t     state;
    logic [4:0] count;

    logic       is_branch;
    logic       rt_is_src;
    logic       hazard;
    logic [4:0] n_cycles;

    logic       stall_c;
    logic       flush_c;
    logic [4:0] left_c;

    // Hazard detection: rt is only a true source for R-type, branches and stores
    always_comb begin
        is_branch = (opcode_id == OPCODE_BEQ) || (opcode_id == OPCODE_BNE);
        rt_is_src = (opcode_id == OPCODE_RTYPE) || is_branch ||
                    (opcode_id == OPCODE_SW);
        hazard    = (opcode_ex == OPCODE_LW) &&
                    ((rt_ex == rs_id) || (rt_is_src && (rt_ex == rt_id)));
        // 5 bits hold the worst case 15 + 7 without wrap
        n_cycles  = 5'(LOAD_LAT) + (is_branch ? 5'(BR_EXTRA) : 5'd0);
    end

    // Output decode; stall in IDLE is combinational so the detection cycle
    // already counts as the first stall cycle
    always_comb begin
        stall_c = 1'b0;
        flush_c = 1'b0;
        left_c  = 5'd0;
        case (state)
            IDLE: begin
                flush_c = irq;
                stall_c = hazard && !irq;
                left_c  = stall_c ? (n_cycles - 5'd1) : 5'd0;
            end
            STALL: begin
                flush_c = irq;
                stall_c = !irq;
                left_c  = irq ? 5'd0 : count;
            end
            FLUSH: begin
                flush_c = irq;
            end
            default: begin
                stall_c = 1'b0;
            end
        endcase
    end

    // Outputs are forced low while reset is held, even with a hazard on the
    // inputs. stall_left saturates at 15 for configurations where N exceeds 16.
    always_comb begin
        stall      = stall_c && !reset;
        flush      = flush_c && !reset;
        stall_left = 4'd0;
        if (!reset) begin
            stall_left = (left_c > 5'd15) ? 4'hF : left_c[3:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            count <= 5'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (irq) begin
                        state <= FLUSH;
                        count <= 5'd0;
                    end else if (hazard && (n_cycles > 5'd1)) begin
                        // Detection cycle is stall #1, so N-2 cycles remain
                        // after the first STALL cycle
                        state <= STALL;
                        count <= n_cycles - 5'd2;
                    end
                end
                STALL: begin
                    if (irq) begin
                        state <= FLUSH;
                        count <= 5'd0;
                    end else if (count == 5'd0) begin
                        state <= IDLE;
                    end else begin
                        count <= count - 5'd1;
                    end
                end
                FLUSH: begin
                    state <= irq ? FLUSH : IDLE;
                    count <= 5'd0;
                end
                default: begin
                    state <= IDLE;
                    count <= 5'd0;
                end
            endcase
        end
    end

`ifdef HAZARD_STALL_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles <= 16'd0;
        end else if (stall && (stall_cycles != 16'hFFFF)) begin
            stall_cycles <= stall_cycles + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_stall_ctrl
//
// Three instances with different latency settings share one stimulus:
//   u0: LOAD_LAT=1, BR_EXTRA=1
//   u1: LOAD_LAT=2, BR_EXTRA=1
//   u2: LOAD_LAT=3, BR_EXTRA=0
// Single-cycle vectors come from a table; multi-cycle behaviour (stall
// countdown, irq abort, reset mid-stall, statistics) uses hand sequences.
// -----------------------------------------------------------------------------
module tb_hazard_stall_ctrl;

    localparam logic [5:0] OP_ADD  = 6'h00;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode_id, opcode_ex;
    logic [1:0] rs_id, rt_id, rt_ex;
    logic       irq;

    logic       stall0, flush0, stall1, flush1, stall2, flush2;
    logic [3:0] left0, left1, left2;
`ifdef HAZARD_STALL_STATS_EN
    logic [15:0] sc0, sc1, sc2;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.REG_W(2), .OPC_W(6), .LOAD_LAT(1), .BR_EXTRA(1)) u0 (
        .clk(clk), .reset(reset), .opcode_id(opcode_id), .rs_id(rs_id),
        .rt_id(rt_id), .opcode_ex(opcode_ex), .rt_ex(rt_ex), .irq(irq),
        .stall(stall0), .flush(flush0), .stall_left(left0)
`ifdef HAZARD_STALL_STATS_EN
        , .stall_cycles(sc0)
`endif
    );

    hazard_stall_ctrl #(.REG_W(2), .OPC_W(6), .LOAD_LAT(2), .BR_EXTRA(1)) u1 (
        .clk(clk), .reset(reset), .opcode_id(opcode_id), .rs_id(rs_id),
        .rt_id(rt_id), .opcode_ex(opcode_ex), .rt_ex(rt_ex), .irq(irq),
        .stall(stall1), .flush(flush1), .stall_left(left1)
`ifdef HAZARD_STALL_STATS_EN
        , .stall_cycles(sc1)
`endif
    );

    hazard_stall_ctrl #(.REG_W(2), .OPC_W(6), .LOAD_LAT(3), .BR_EXTRA(0)) u2 (
        .clk(clk), .reset(reset), .opcode_id(opcode_id), .rs_id(rs_id),
        .rt_id(rt_id), .opcode_ex(opcode_ex), .rt_ex(rt_ex), .irq(irq),
        .stall(stall2), .flush(flush2), .stall_left(left2)
`ifdef HAZARD_STALL_STATS_EN
        , .stall_cycles(sc2)
`endif
    );

    typedef struct {
        logic [5:0] opc_id;
        logic [1:0] rs;
        logic [1:0] rt;
        logic [5:0] opc_ex;
        logic [1:0] rtx;
        logic       irq;
        logic       stall;
        logic       flush;
        logic [3:0] l0;
        logic [3:0] l1;
        logic [3:0] l2;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [5:0] oid, input logic [1:0] rs, input logic [1:0] rt,
                         input logic [5:0] oex, input logic [1:0] rtx, input logic i);
        opcode_id = oid;
        rs_id     = rs;
        rt_id     = rt;
        opcode_ex = oex;
        rt_ex     = rtx;
        irq       = i;
    endtask

    task automatic drain();
        drive(OP_ADD, 2'd0, 2'd0, OP_ADDI, 2'd0, 1'b0);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        // opc_id rs rt opc_ex rt_ex irq | stall flush l0 l1 l2
        vecs[0] = '{OP_ADD,  2'd1, 2'd2, OP_LW,   2'd1, 1'b0, 1'b1, 1'b0, 4'd0, 4'd1, 4'd2};
        vecs[1] = '{OP_BEQ,  2'd0, 2'd2, OP_LW,   2'd2, 1'b0, 1'b1, 1'b0, 4'd1, 4'd2, 4'd2};
        vecs[2] = '{OP_ADDI, 2'd0, 2'd3, OP_LW,   2'd3, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0};
        vecs[3] = '{OP_SW,   2'd0, 2'd3, OP_LW,   2'd3, 1'b0, 1'b1, 1'b0, 4'd0, 4'd1, 4'd2};
        vecs[4] = '{OP_ADD,  2'd1, 2'd0, OP_ADD,  2'd1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0};
        vecs[5] = '{OP_ADD,  2'd1, 2'd0, OP_LW,   2'd1, 1'b1, 1'b0, 1'b1, 4'd0, 4'd0, 4'd0};
        vecs[6] = '{OP_LW,   2'd0, 2'd2, OP_LW,   2'd2, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0};
        vecs[7] = '{OP_BNE,  2'd0, 2'd1, OP_LW,   2'd0, 1'b0, 1'b1, 1'b0, 4'd1, 4'd2, 4'd2};
        vecs[8] = '{OP_ADD,  2'd0, 2'd0, OP_ADDI, 2'd0, 1'b1, 1'b0, 1'b1, 4'd0, 4'd0, 4'd0};
        vecs[9] = '{OP_ORI,  2'd2, 2'd1, OP_LW,   2'd1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0};

        // Reset held with a hazard on the inputs: outputs must be quiet
        reset = 1'b1;
        drive(OP_ADD, 2'd1, 2'd0, OP_LW, 2'd1, 1'b0);
        @(negedge clk);
        #1;
        chk("rst_stall", {15'd0, stall0}, 16'd0);
        chk("rst_flush", {15'd0, flush0}, 16'd0);
        chk("rst_left",  {12'd0, left2}, 16'd0);
        $display("txn reset: stall=%0b flush=%0b left=%0d", stall0, flush0, left2);
        @(negedge clk);
        reset = 1'b0;
        drain();

        // Table-driven single-cycle vectors, each started from IDLE
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive(vecs[i].opc_id, vecs[i].rs, vecs[i].rt, vecs[i].opc_ex, vecs[i].rtx, vecs[i].irq);
            #1;
            $display("txn vec%0d: opc_id=%0h rs=%0d rt=%0d opc_ex=%0h rt_ex=%0d irq=%0b -> stall=%0b flush=%0b left=%0d/%0d/%0d",
                     i, vecs[i].opc_id, vecs[i].rs, vecs[i].rt, vecs[i].opc_ex, vecs[i].rtx,
                     vecs[i].irq, stall0, flush0, left0, left1, left2);
            chk($sformatf("vec%0d_stall", i), {13'd0, stall0, stall1, stall2},
                {13'd0, vecs[i].stall, vecs[i].stall, vecs[i].stall});
            chk($sformatf("vec%0d_flush", i), {13'd0, flush0, flush1, flush2},
                {13'd0, vecs[i].flush, vecs[i].flush, vecs[i].flush});
            chk($sformatf("vec%0d_left0", i), {12'd0, left0}, {12'd0, vecs[i].l0});
            chk($sformatf("vec%0d_left1", i), {12'd0, left1}, {12'd0, vecs[i].l1});
            chk($sformatf("vec%0d_left2", i), {12'd0, left2}, {12'd0, vecs[i].l2});
            drain();
        end

        // u1 (N=3 for a branch): countdown 2,1,0 while inputs change
        @(negedge clk);
        drive(OP_BEQ, 2'd0, 2'd2, OP_LW, 2'd2, 1'b0);
        for (int c = 0; c < 4; c++) begin
            #1;
            $display("txn br_seq c%0d: stall=%0b left=%0d", c, stall1, left1);
            chk($sformatf("br_seq%0d_stall", c), {15'd0, stall1}, (c < 3) ? 16'd1 : 16'd0);
            chk($sformatf("br_seq%0d_left", c), {12'd0, left1}, (c < 3) ? 16'(2 - c) : 16'd0);
            @(negedge clk);
            drive(OP_ADD, 2'd0, 2'd0, OP_ADDI, 2'd0, 1'b0);
        end
        drain();

        // u2 (N=3): irq in the second stall cycle, irq again in FLUSH
        @(negedge clk);
        drive(OP_ADD, 2'd1, 2'd0, OP_LW, 2'd1, 1'b0);
        #1;
        chk("irq_c0_stall", {15'd0, stall2}, 16'd1);
        chk("irq_c0_left", {12'd0, left2}, 16'd2);
        @(negedge clk);
        drive(OP_ADD, 2'd0, 2'd0, OP_ADDI, 2'd0, 1'b1);
        #1;
        $display("txn irq_abort: stall=%0b flush=%0b left=%0d", stall2, flush2, left2);
        chk("irq_c1_stall", {15'd0, stall2}, 16'd0);
        chk("irq_c1_flush", {15'd0, flush2}, 16'd1);
        chk("irq_c1_left", {12'd0, left2}, 16'd0);
        @(negedge clk);
        #1;
        chk("irq_reflush", {15'd0, flush2}, 16'd1);
        @(negedge clk);
        irq = 1'b0;
        #1;
        $display("txn irq_flush_state: stall=%0b flush=%0b", stall2, flush2);
        chk("irq_fl_flush", {15'd0, flush2}, 16'd0);
        chk("irq_fl_stall", {15'd0, stall2}, 16'd0);
        @(negedge clk);
        drive(OP_ADD, 2'd1, 2'd0, OP_LW, 2'd1, 1'b0);
        #1;
        chk("irq_back_idle_stall", {15'd0, stall2}, 16'd1);
        chk("irq_back_idle_left", {12'd0, left2}, 16'd2);
        drain();

        // Reset asserted mid-stall, between clock edges
        @(negedge clk);
        drive(OP_ADD, 2'd1, 2'd0, OP_LW, 2'd1, 1'b0);
        @(negedge clk);
        drive(OP_ADD, 2'd0, 2'd0, OP_ADDI, 2'd0, 1'b0);
        #1;
        chk("mid_stall_pre", {15'd0, stall2}, 16'd1);
        drive(OP_ADD, 2'd1, 2'd0, OP_LW, 2'd1, 1'b0);
        #1;
        reset = 1'b1;
        #1;
        $display("txn reset_mid_stall: stall=%0b flush=%0b left=%0d", stall2, flush2, left2);
        chk("mid_rst_outs2", {11'd0, stall2, flush2, left2}, 16'd0);
        chk("mid_rst_outs0", {11'd0, stall0, flush0, left0}, 16'd0);
        @(negedge clk);
        reset = 1'b0;
        drive(OP_ADD, 2'd0, 2'd0, OP_ADDI, 2'd0, 1'b0);
        #1;
        chk("post_rst_flush", {14'd0, flush2, stall2}, 16'd0);
        drain();

`ifdef HAZARD_STALL_STATS_EN
        // Four branch hazards on u0 (N=2) give 8 stall cycles
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int h = 0; h < 4; h++) begin
            @(negedge clk);
            drive(OP_BEQ, 2'd1, 2'd0, OP_LW, 2'd1, 1'b0);
            @(negedge clk);
            drain();
        end
        $display("txn stats_4x2: stall_cycles=%0d", sc0);
        chk("stats_4x2", sc0, 16'd8);

        // Continuous N=1 hazard on u0 stalls every cycle: saturation check
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        drive(OP_ADD, 2'd1, 2'd0, OP_LW, 2'd1, 1'b0);
        repeat (65534) @(negedge clk);
        $display("txn stats_preload: stall_cycles=%0h", sc0);
        chk("stats_fffe", sc0, 16'hFFFE);
        repeat (3) @(negedge clk);
        $display("txn stats_saturate: stall_cycles=%0h", sc0);
        chk("stats_sat", sc0, 16'hFFFF);
        drain();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
